// File: rtl/ysyx_24080006_pkg.sv
// Shared types and sizing for the scoreboard (in-order reorder buffer).
//   SB_NR_ENTRIES  : default buffer depth (power of two, >= 2)
//   SB_NR_WB_PORTS : default number of functional-unit writeback ports
//   decoder_t      : decoded instruction carried from issue to commit
//   sb_entry_t     : one buffer slot (occupancy, completion, instruction)
package ysyx_24080006_pkg;

  localparam int unsigned SB_NR_ENTRIES  = 4;
  localparam int unsigned SB_NR_WB_PORTS = 2;
  localparam int unsigned TRANS_ID_BITS  = $clog2(SB_NR_ENTRIES);
  localparam int unsigned REG_ADDR_W     = 5;
  localparam int unsigned XLEN           = 32;

  typedef struct packed {
    logic                     valid;
    logic [TRANS_ID_BITS-1:0] trans_id;
    logic [REG_ADDR_W-1:0]    rd;
    logic [XLEN-1:0]          result;
  } decoder_t;

  typedef struct packed {
    logic     occupied;
    logic     finished;
    decoder_t instr;
  } sb_entry_t;

endpackage

// File: rtl/scoreboard_if.sv
// Issue / writeback / commit bundle of the scoreboard.
//   master : issue stage, functional units and commit stage
//   slave  : the scoreboard itself
interface scoreboard_if
  import ysyx_24080006_pkg::*;
#(
  parameter int unsigned NR_WB_PORTS = SB_NR_WB_PORTS
) ();

  logic                                        flush_i;
  decoder_t                                    issue_instr_i;
  logic                                        issue_valid_i;
  logic                                        issue_ready_o;
  logic [TRANS_ID_BITS-1:0]                    issue_id_o;
  logic [NR_WB_PORTS-1:0]                      wb_valid_i;
  logic [NR_WB_PORTS-1:0][TRANS_ID_BITS-1:0]   wb_id_i;
  logic [NR_WB_PORTS-1:0][XLEN-1:0]            wb_result_i;
  decoder_t                                    commit_instr_o;
  logic                                        commit_ack_i;

  modport master (
    output flush_i, issue_instr_i, issue_valid_i,
    output wb_valid_i, wb_id_i, wb_result_i, commit_ack_i,
    input  issue_ready_o, issue_id_o, commit_instr_o
  );

  modport slave (
    input  flush_i, issue_instr_i, issue_valid_i,
    input  wb_valid_i, wb_id_i, wb_result_i, commit_ack_i,
    output issue_ready_o, issue_id_o, commit_instr_o
  );

endinterface

// File: rtl/scoreboard.sv
// In-order reorder buffer feeding the commit stage.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   sb (slave)    : flush, issue request/ready/id, per-port writeback,
//                   commit instruction (head) and commit acknowledge
// Outputs are decoded from registers only; no input reaches them in the
// same cycle.
module scoreboard
  import ysyx_24080006_pkg::*;
#(
  parameter int unsigned NR_ENTRIES  = SB_NR_ENTRIES,
  parameter int unsigned NR_WB_PORTS = SB_NR_WB_PORTS
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  scoreboard_if.slave   sb
);

  localparam int unsigned CNT_W = TRANS_ID_BITS + 1;

  sb_entry_t                mem_q [NR_ENTRIES];
  logic [TRANS_ID_BITS-1:0] head_q;
  logic [TRANS_ID_BITS-1:0] tail_q;
  logic [CNT_W-1:0]         count_q;

  logic      issue_ready;
  logic      issue_fire;
  logic      commit_valid;
  logic      commit_fire;
  sb_entry_t issue_entry;
  decoder_t  commit_instr;

  // Ready looks only at the registered count: a same-cycle retire does not
  // open a slot for issue.
  assign issue_ready  = (count_q != CNT_W'(NR_ENTRIES));
  assign issue_fire   = sb.issue_valid_i && issue_ready;
  assign commit_valid = mem_q[head_q].occupied && mem_q[head_q].finished;
  assign commit_fire  = commit_valid && sb.commit_ack_i;

  // Entry written at the tail; its ID is the tail slot.
  always_comb begin
    issue_entry                = '0;
    issue_entry.occupied       = 1'b1;
    issue_entry.finished       = 1'b0;
    issue_entry.instr          = sb.issue_instr_i;
    issue_entry.instr.valid    = 1'b0;
    issue_entry.instr.trans_id = tail_q;
  end

  // Head presented to commit; valid only once it has been written back.
  always_comb begin
    commit_instr       = mem_q[head_q].instr;
    commit_instr.valid = commit_valid;
  end

  assign sb.issue_ready_o  = issue_ready;
  assign sb.issue_id_o     = tail_q;
  assign sb.commit_instr_o = commit_instr;

  // Storage, pointers and occupancy.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        mem_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (sb.flush_i) begin
      for (int unsigned i = 0; i < NR_ENTRIES; i++) begin
        mem_q[i].occupied <= 1'b0;
        mem_q[i].finished <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      // Highest port first so the lowest-indexed port's write lands last.
      for (int p = NR_WB_PORTS - 1; p >= 0; p--) begin
        if (sb.wb_valid_i[p] && mem_q[sb.wb_id_i[p]].occupied) begin
          mem_q[sb.wb_id_i[p]].finished     <= 1'b1;
          mem_q[sb.wb_id_i[p]].instr.result <= sb.wb_result_i[p];
        end
      end
      if (issue_fire) begin
        mem_q[tail_q] <= issue_entry;
        tail_q        <= tail_q + TRANS_ID_BITS'(1);
      end
      if (commit_fire) begin
        mem_q[head_q].occupied <= 1'b0;
        mem_q[head_q].finished <= 1'b0;
        head_q                 <= head_q + TRANS_ID_BITS'(1);
      end
      unique case ({issue_fire, commit_fire})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_scoreboard.sv
// Directed bench for the scoreboard with NR_ENTRIES=4, NR_WB_PORTS=2.
module tb_scoreboard;
  import ysyx_24080006_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  scoreboard_if #(.NR_WB_PORTS(2)) sb_if ();

  scoreboard #(.NR_ENTRIES(4), .NR_WB_PORTS(2)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .sb     (sb_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    sb_if.flush_i       = 1'b0;
    sb_if.issue_instr_i = '0;
    sb_if.issue_valid_i = 1'b0;
    sb_if.wb_valid_i    = '0;
    sb_if.wb_id_i       = '0;
    sb_if.wb_result_i   = '0;
    sb_if.commit_ack_i  = 1'b0;
  endtask

  // Advance one edge, then drop all requests; sampling happens 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_issue(input logic [4:0] rd);
    sb_if.issue_valid_i    = 1'b1;
    sb_if.issue_instr_i    = '0;
    sb_if.issue_instr_i.rd = rd;
    tick();
  endtask

  task automatic do_wb(input int p, input logic [1:0] id, input logic [31:0] res);
    sb_if.wb_valid_i[p]  = 1'b1;
    sb_if.wb_id_i[p]     = id;
    sb_if.wb_result_i[p] = res;
  endtask

  task automatic check_head(input string tag, input logic v, input logic [1:0] id,
                            input logic [4:0] rd, input logic [31:0] res);
    check({tag, "_valid"}, 32'(sb_if.commit_instr_o.valid), 32'(v));
    check({tag, "_id"},    32'(sb_if.commit_instr_o.trans_id), 32'(id));
    check({tag, "_rd"},    32'(sb_if.commit_instr_o.rd), 32'(rd));
    check({tag, "_res"},   sb_if.commit_instr_o.result, res);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    idle_inputs();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 32'(sb_if.issue_ready_o), 32'd1);
    check("rst_id", 32'(sb_if.issue_id_o), 32'd0);
    check_head("rst_head", 1'b0, 2'd0, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("idle_ready", 32'(sb_if.issue_ready_o), 32'd1);
    check("idle_valid", 32'(sb_if.commit_instr_o.valid), 32'd0);

    // Single instruction: issue, writeback next cycle, commit.
    do_issue(5'd5);
    check("t1_id", 32'(sb_if.issue_id_o), 32'd1);
    check("t1_cnt", 32'(dut.count_q), 32'd1);
    check("t1_notfin", 32'(sb_if.commit_instr_o.valid), 32'd0);
    do_wb(0, 2'd0, 32'h1234);
    tick();
    check_head("t1_head", 1'b1, 2'd0, 5'd5, 32'h1234);
    sb_if.commit_ack_i = 1'b1;
    tick();
    check("t1_post_valid", 32'(sb_if.commit_instr_o.valid), 32'd0);
    check("t1_post_cnt", 32'(dut.count_q), 32'd0);

    // Fill to capacity starting from slot 1 (wraps to 0).
    do_issue(5'd1);
    do_issue(5'd2);
    do_issue(5'd3);
    check("full_ready3", 32'(sb_if.issue_ready_o), 32'd1);
    do_issue(5'd4);
    check("full_ready", 32'(sb_if.issue_ready_o), 32'd0);
    check("full_cnt", 32'(dut.count_q), 32'd4);
    check("full_id", 32'(sb_if.issue_id_o), 32'd1);
    do_wb(1, 2'd1, 32'h11);
    tick();
    check_head("full_head", 1'b1, 2'd1, 5'd1, 32'h11);
    // Issue while full plus retire: issue must be refused.
    sb_if.issue_valid_i    = 1'b1;
    sb_if.issue_instr_i.rd = 5'd31;
    sb_if.commit_ack_i     = 1'b1;
    tick();
    check("full_cnt_after", 32'(dut.count_q), 32'd3);
    check("full_ready_after", 32'(sb_if.issue_ready_o), 32'd1);
    check("full_id_after", 32'(sb_if.issue_id_o), 32'd1);
    check("full_valid_after", 32'(sb_if.commit_instr_o.valid), 32'd0);
    // Ack on an unfinished head is ignored.
    sb_if.commit_ack_i = 1'b1;
    tick();
    check("ack_idle_cnt", 32'(dut.count_q), 32'd3);

    // Flush with a concurrent issue and writeback.
    sb_if.flush_i       = 1'b1;
    sb_if.issue_valid_i = 1'b1;
    do_wb(0, 2'd2, 32'hdead);
    tick();
    check("fl_cnt", 32'(dut.count_q), 32'd0);
    check("fl_id", 32'(sb_if.issue_id_o), 32'd0);
    check("fl_valid", 32'(sb_if.commit_instr_o.valid), 32'd0);
    check("fl_ready", 32'(sb_if.issue_ready_o), 32'd1);
    do_issue(5'd6);
    check("fl_next_id", 32'(sb_if.issue_id_o), 32'd1);
    check("fl_next_valid", 32'(sb_if.commit_instr_o.valid), 32'd0);

    // Out-of-order writeback, in-order commit.
    do_issue(5'd7);
    do_issue(5'd8);
    check("ooo_cnt", 32'(dut.count_q), 32'd3);
    do_wb(0, 2'd2, 32'h22);
    tick();
    check("ooo_wb2", 32'(sb_if.commit_instr_o.valid), 32'd0);
    do_wb(1, 2'd1, 32'h21);
    tick();
    check("ooo_wb1", 32'(sb_if.commit_instr_o.valid), 32'd0);
    do_wb(0, 2'd0, 32'h20);
    tick();
    check_head("ooo_c0", 1'b1, 2'd0, 5'd6, 32'h20);
    sb_if.commit_ack_i = 1'b1;
    tick();
    check_head("ooo_c1", 1'b1, 2'd1, 5'd7, 32'h21);
    sb_if.commit_ack_i = 1'b1;
    tick();
    check_head("ooo_c2", 1'b1, 2'd2, 5'd8, 32'h22);
    sb_if.commit_ack_i = 1'b1;
    tick();
    check("ooo_end_valid", 32'(sb_if.commit_instr_o.valid), 32'd0);
    check("ooo_end_cnt", 32'(dut.count_q), 32'd0);

    // Two ports hit the same ID: port 0 wins. Writeback to a free slot is dropped.
    sb_if.flush_i = 1'b1;
    tick();
    do_issue(5'd10);
    do_issue(5'd11);
    do_wb(0, 2'd1, 32'hAAAA);
    do_wb(1, 2'd1, 32'hBBBB);
    tick();
    do_wb(0, 2'd2, 32'h99);
    do_wb(1, 2'd0, 32'h30);
    tick();
    check_head("dp_c0", 1'b1, 2'd0, 5'd10, 32'h30);
    sb_if.commit_ack_i = 1'b1;
    tick();
    check_head("dp_c1", 1'b1, 2'd1, 5'd11, 32'hAAAA);
    sb_if.commit_ack_i = 1'b1;
    tick();
    do_issue(5'd12);
    check("dp_free_wb", 32'(sb_if.commit_instr_o.valid), 32'd0);
    check("dp_cnt", 32'(dut.count_q), 32'd1);

    // Asynchronous reset mid-operation.
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_cnt", 32'(dut.count_q), 32'd0);
    check("arst_ready", 32'(sb_if.issue_ready_o), 32'd1);
    check("arst_id", 32'(sb_if.issue_id_o), 32'd0);
    check_head("arst_head", 1'b0, 2'd0, 5'd0, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
